am2940_controller: RTL and testbench
====================================

AM2940_CONTROLLER -- requirements
Module: am2940_controller

Interface
REQ-001 SHALL have: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: res  in  1  synchronous active-low reset.
REQ-003 SHALL have: instr  in  3  Am2940 instruction code (0 WR_CR, 1 RD_CR, 2 RD_WC, 3 RD_ADDR, 4 REINIT, 5 LOAD_ADDR, 6 LOAD_WC, 7 ENABLE).
REQ-004 SHALL have: instr_valid  in  1  instr sampled this cycle.
REQ-005 SHALL have: bus_data_in  in  4  write data.
REQ-006 SHALL have: addr_in  in  4  address_out of the address path.
REQ-007 SHALL have: cnte  in  1  transfer-step request.
REQ-008 SHALL have: bus_data_out  out  4  read data (0 when bus_oe=0).
REQ-009 SHALL have: bus_oe  out  1  read-data valid.
REQ-010 SHALL have: plar, plac, sela, ena, inca, aci  out  1 each  address-path controls.
REQ-011 SHALL have: done  out  1  transfer complete; busy  out  1  state==RUN.

Function
REQ-012 SHALL hold registers: cr[3:0] (cr[1:0] mode, cr[2] direction 1=decrement, cr[3] spare, read back), wcr[3:0] word-count register, wc[3:0] word counter, FSM {IDLE, RUN, DONE}.
REQ-013 SHALL decode instructions combinationally, effective in the cycle instr_valid=1, in any state.
REQ-014 WR_CR: cr<=bus_data_in; RD_CR/RD_WC/RD_ADDR: bus_oe=1, bus_data_out=cr/wc/addr_in, same cycle.
REQ-015 LOAD_ADDR: plar=1, plac=1, sela=0 that cycle.
REQ-016 LOAD_WC: wcr<=bus_data_in; wc<=0 if mode 01, else bus_data_in.
REQ-017 REINIT: plac=1, sela=1; wc<=0 if mode 01, else wcr.
REQ-018 LOAD_ADDR, LOAD_WC, REINIT, WR_CR in RUN or DONE SHALL force state IDLE.
REQ-019 ENABLE: IDLE/DONE->RUN; no effect in RUN; modes 00/11 with wc==0 go directly to DONE.
REQ-020 Step: RUN & cnte & ~instr_valid & no terminal condition -> ena=1, aci=1 same cycle, wc updates on the edge; instr_valid suppresses the step.
REQ-021 inca SHALL equal ~cr[2] at all times.
REQ-022 Mode 00: wc decrements; step taking wc 1->0 moves RUN->DONE.
REQ-023 Mode 01: wc increments; step with wc+1==wcr moves RUN->DONE; wcr==0 wraps after 16 steps.
REQ-024 Mode 10: in RUN, addr_in==wcr SHALL suppress ena and move RUN->DONE; wc decrements per step, mod 16.
REQ-025 Mode 11: wc decrements; step taking 1->0 reloads wc<=wcr, pulses done one cycle, stays RUN (no address reload).
REQ-026 done SHALL be high throughout DONE; ena=0 in IDLE/DONE.
REQ-027 4-bit counters SHALL wrap modulo 16.

Reset
REQ-028 res=0 at an edge: cr=0, wcr=0, wc=0, state IDLE; overrides any instruction, including mid-transfer.
REQ-029 Outputs after reset (no instr_valid): plar=plac=sela=ena=aci=0, inca=1, done=0, busy=0, bus_oe=0, bus_data_out=0.

Configuration
REQ-030 Macro AM2940_AUTO_REINIT_EN defined: one cycle after entering DONE, controller SHALL perform REINIT internally (plac=1, sela=1, wc reload) and enter IDLE; done high exactly one cycle.
REQ-031 Macro undefined: DONE persists until an instruction or reset.

Verification
REQ-032 Reset: res=0 two cycles with instr_valid=1 -> all REQ-029 values, state IDLE.
REQ-033 Mode 00: WR_CR 0000, LOAD_WC 0011, ENABLE, cnte=1 -> exactly 3 ena pulses, wc 3->0, done high, ena 0 after.
REQ-034 Mode 01: WR_CR 0101, LOAD_WC 0100, ENABLE, cnte=1 -> wc 0..3, 4 ena pulses, inca=0, done.
REQ-035 Mode 10: WR_CR 0010, LOAD_WC 0110, drive addr_in 3,4,5,6 -> done when addr_in=6, no ena that cycle.
REQ-036 Mode 11: wcr=2, cnte=1 for 6 cycles -> done pulses at steps 2,4,6; busy stays 1; LOAD_ADDR mid-run -> IDLE, plar=plac=1.
REQ-037 Mode 00, wcr=5, res=0 after 2 steps -> wc=0, IDLE, ena=0; auto-reinit build: done one cycle then plac=1, sela=1, IDLE.

Source files
------------

// File: rtl/am2940_controller_if.sv
// Instruction, data-bus and address-path control signals of the Am2940-style controller.
// The master side drives instructions and bus data; the slave side is the controller.
interface am2940_controller_if;
    logic [2:0] instr;
    logic       instr_valid;
    logic [3:0] bus_data_in;
    logic [3:0] addr_in;
    logic       cnte;
    logic [3:0] bus_data_out;
    logic       bus_oe;
    logic       plar;
    logic       plac;
    logic       sela;
    logic       ena;
    logic       inca;
    logic       aci;
    logic       done;
    logic       busy;

    modport master (
        output instr, instr_valid, bus_data_in, addr_in, cnte,
        input  bus_data_out, bus_oe, plar, plac, sela, ena, inca, aci, done, busy
    );

    modport slave (
        input  instr, instr_valid, bus_data_in, addr_in, cnte,
        output bus_data_out, bus_oe, plar, plac, sela, ena, inca, aci, done, busy
    );
endinterface

// File: rtl/am2940_controller.sv
// Am2940-style DMA address/word-count controller: control, word-count and transfer FSM.
// Optional AM2940_AUTO_REINIT_EN: DONE lasts one cycle and then reinitialises into IDLE.
module am2940_controller (
    input logic                clk,
    input logic                res,
    am2940_controller_if.slave bus
);

    localparam logic [2:0] InstrWrCr     = 3'd0;
    localparam logic [2:0] InstrRdCr     = 3'd1;
    localparam logic [2:0] InstrRdWc     = 3'd2;
    localparam logic [2:0] InstrRdAddr   = 3'd3;
    localparam logic [2:0] InstrReinit   = 3'd4;
    localparam logic [2:0] InstrLoadAddr = 3'd5;
    localparam logic [2:0] InstrLoadWc   = 3'd6;
    localparam logic [2:0] InstrEnable   = 3'd7;

    localparam logic [1:0] ModeDec   = 2'b00;
    localparam logic [1:0] ModeInc   = 2'b01;
    localparam logic [1:0] ModeAddr  = 2'b10;
    localparam logic [1:0] ModeCycle = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cr_q, cr_d;
    logic [3:0] wcr_q, wcr_d;
    logic [3:0] wc_q, wc_d;
    logic       pulse_q, pulse_d;

    logic [1:0] mode;
    logic [3:0] wc_inc;
    logic [3:0] wc_dec;
    logic [3:0] wc_reinit;
    logic       wc_zero;
    logic       wc_one;
    logic       terminal;
    logic       start_done;

    assign mode      = cr_q[1:0];
    assign wc_inc    = wc_q + 4'd1;
    assign wc_dec    = wc_q - 4'd1;
    assign wc_zero   = (wc_q == 4'd0);
    assign wc_one    = (wc_q == 4'd1);
    // Count-up mode always restarts from zero; the others restart from the stored count.
    assign wc_reinit = (mode == ModeInc) ? 4'd0 : wcr_q;

    // Stop conditions evaluated while running, before any step is taken.
    always_comb begin
        terminal = 1'b0;
        case (mode)
            ModeAddr: terminal = (bus.addr_in == wcr_q);
            ModeInc:  terminal = 1'b0;
            default:  terminal = wc_zero;
        endcase
    end

    assign start_done = ((mode == ModeDec) || (mode == ModeCycle)) && wc_zero;

    always_comb begin
        state_d          = state_q;
        cr_d             = cr_q;
        wcr_d            = wcr_q;
        wc_d             = wc_q;
        pulse_d          = 1'b0;
        bus.bus_oe       = 1'b0;
        bus.bus_data_out = 4'd0;
        bus.plar         = 1'b0;
        bus.plac         = 1'b0;
        bus.sela         = 1'b0;
        bus.ena          = 1'b0;
        bus.aci          = 1'b0;

        case (state_q)
            StRun: begin
                if (terminal) begin
                    state_d = StDone;
                end else if (bus.cnte && !bus.instr_valid) begin
                    bus.ena = 1'b1;
                    bus.aci = 1'b1;
                    case (mode)
                        ModeInc: begin
                            wc_d = wc_inc;
                            if (wc_inc == wcr_q) begin
                                state_d = StDone;
                            end
                        end
                        ModeAddr: begin
                            wc_d = wc_dec;
                        end
                        ModeCycle: begin
                            if (wc_one) begin
                                wc_d    = wcr_q;
                                pulse_d = 1'b1;
                            end else begin
                                wc_d = wc_dec;
                            end
                        end
                        default: begin
                            wc_d = wc_dec;
                            if (wc_one) begin
                                state_d = StDone;
                            end
                        end
                    endcase
                end
            end
            StDone: begin
`ifdef AM2940_AUTO_REINIT_EN
                // An explicit instruction in the DONE cycle takes precedence over the reinit.
                if (!bus.instr_valid) begin
                    bus.plac = 1'b1;
                    bus.sela = 1'b1;
                    wc_d     = wc_reinit;
                    state_d  = StIdle;
                end
`endif
            end
            default: ;
        endcase

        if (bus.instr_valid) begin
            unique case (bus.instr)
                InstrWrCr: begin
                    cr_d    = bus.bus_data_in;
                    state_d = StIdle;
                end
                InstrRdCr: begin
                    bus.bus_oe       = 1'b1;
                    bus.bus_data_out = cr_q;
                end
                InstrRdWc: begin
                    bus.bus_oe       = 1'b1;
                    bus.bus_data_out = wc_q;
                end
                InstrRdAddr: begin
                    bus.bus_oe       = 1'b1;
                    bus.bus_data_out = bus.addr_in;
                end
                InstrReinit: begin
                    bus.plac = 1'b1;
                    bus.sela = 1'b1;
                    wc_d     = wc_reinit;
                    state_d  = StIdle;
                end
                InstrLoadAddr: begin
                    bus.plar = 1'b1;
                    bus.plac = 1'b1;
                    state_d  = StIdle;
                end
                InstrLoadWc: begin
                    wcr_d   = bus.bus_data_in;
                    wc_d    = (mode == ModeInc) ? 4'd0 : bus.bus_data_in;
                    state_d = StIdle;
                end
                InstrEnable: begin
                    if (state_q != StRun) begin
                        state_d = start_done ? StDone : StRun;
                    end
                end
            endcase
        end
    end

    assign bus.inca = ~cr_q[2];
    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone) || pulse_q;

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q <= StIdle;
            cr_q    <= 4'd0;
            wcr_q   <= 4'd0;
            wc_q    <= 4'd0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cr_q    <= cr_d;
            wcr_q   <= wcr_d;
            wc_q    <= wc_d;
            pulse_q <= pulse_d;
        end
    end

endmodule

// File: tb/tb_am2940_controller.sv
// Directed self-checking bench for am2940_controller; expectations follow the mode rules,
// with AM2940_AUTO_REINIT_EN selecting the one-cycle DONE variants.
module tb_am2940_controller;

    localparam logic [2:0] WrCr     = 3'd0;
    localparam logic [2:0] RdCr     = 3'd1;
    localparam logic [2:0] RdWc     = 3'd2;
    localparam logic [2:0] RdAddr   = 3'd3;
    localparam logic [2:0] LoadAddr = 3'd5;
    localparam logic [2:0] LoadWc   = 3'd6;
    localparam logic [2:0] Enable   = 3'd7;

`ifdef AM2940_AUTO_REINIT_EN
    localparam logic AutoReinit = 1'b1;
`else
    localparam logic AutoReinit = 1'b0;
`endif

    logic clk = 1'b0;
    logic res = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    am2940_controller_if bus ();

    am2940_controller dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] data);
        bus.instr       = op;
        bus.bus_data_in = data;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
    endtask

    task automatic read_check(input logic [2:0] op, input string tag, input logic [3:0] exp);
        bus.instr       = op;
        bus.instr_valid = 1'b1;
        #1;
        check_eq({tag, "_oe"}, bus.bus_oe, 1);
        check_eq(tag, bus.bus_data_out, exp);
        tick();
        bus.instr_valid = 1'b0;
    endtask

    // Counts ena pulses until done rises; a missing done shows up in the caller's checks.
    task automatic run_until_done(input int budget, output int pulses);
        pulses = 0;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (bus.done) break;
            if (bus.ena) pulses++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int       pulses;
        int       busy_cnt;
        int       ena_cnt;
        logic [5:0] mask;

        // Reset held two cycles while an ENABLE is presented.
        bus.instr       = Enable;
        bus.instr_valid = 1'b1;
        bus.bus_data_in = 4'hf;
        bus.addr_in     = 4'h0;
        bus.cnte        = 1'b1;
        tick();
        tick();
        res             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.cnte        = 1'b0;
        #1;
        check_eq("rst_plar", bus.plar, 0);
        check_eq("rst_plac", bus.plac, 0);
        check_eq("rst_sela", bus.sela, 0);
        check_eq("rst_ena", bus.ena, 0);
        check_eq("rst_aci", bus.aci, 0);
        check_eq("rst_inca", bus.inca, 1);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_oe", bus.bus_oe, 0);
        check_eq("rst_data", bus.bus_data_out, 0);
        tick();
        check_eq("rst_idle", bus.busy, 0);
        read_check(RdCr, "rst_cr", 4'h0);
        read_check(RdWc, "rst_wc", 4'h0);
        bus.addr_in = 4'ha;
        read_check(RdAddr, "rd_addr", 4'ha);
        bus.addr_in = 4'h0;

        // Mode 00: count down from 3.
        issue(WrCr, 4'b0000);
        issue(LoadWc, 4'd3);
        read_check(RdWc, "m0_wc_load", 4'd3);
        issue(Enable, 4'd0);
        check_eq("m0_busy", bus.busy, 1);
        bus.cnte = 1'b1;
        #1;
        check_eq("m0_ena_first", bus.ena, 1);
        check_eq("m0_aci_first", bus.aci, 1);
        run_until_done(10, pulses);
        check_eq("m0_pulses", pulses, 3);
        check_eq("m0_done", bus.done, 1);
        check_eq("m0_ena_done", bus.ena, 0);
        check_eq("m0_plac_done", bus.plac, AutoReinit);
        check_eq("m0_sela_done", bus.sela, AutoReinit);
        tick();
        check_eq("m0_done_hold", bus.done, !AutoReinit);
        check_eq("m0_ena_after", bus.ena, 0);
        check_eq("m0_busy_after", bus.busy, 0);
        bus.cnte = 1'b0;
        read_check(RdWc, "m0_wc_end", AutoReinit ? 4'd3 : 4'd0);

        // Mode 01: count up to 4 with decrementing addresses.
        issue(WrCr, 4'b0101);
        check_eq("m1_inca", bus.inca, 0);
        check_eq("m1_idle", bus.done, 0);
        issue(LoadWc, 4'd4);
        read_check(RdWc, "m1_wc_load", 4'd0);
        issue(Enable, 4'd0);
        bus.cnte = 1'b1;
        run_until_done(20, pulses);
        check_eq("m1_pulses", pulses, 4);
        check_eq("m1_done", bus.done, 1);
        tick();
        bus.cnte = 1'b0;
        read_check(RdWc, "m1_wc_end", AutoReinit ? 4'd0 : 4'd4);

        // Mode 10: stop when the address reaches the stored count.
        issue(WrCr, 4'b0010);
        check_eq("m2_inca", bus.inca, 1);
        issue(LoadWc, 4'd6);
        bus.addr_in = 4'd3;
        issue(Enable, 4'd0);
        bus.cnte = 1'b1;
        for (int a = 3; a < 6; a++) begin
            bus.addr_in = 4'(a);
            #1;
            check_eq($sformatf("m2_ena_a%0d", a), bus.ena, 1);
            tick();
        end
        bus.addr_in = 4'd6;
        #1;
        check_eq("m2_ena_match", bus.ena, 0);
        check_eq("m2_busy_match", bus.busy, 1);
        tick();
        check_eq("m2_done", bus.done, 1);
        check_eq("m2_busy_done", bus.busy, 0);
        tick();
        bus.cnte    = 1'b0;
        bus.addr_in = 4'd0;
        read_check(RdWc, "m2_wc_end", AutoReinit ? 4'd6 : 4'd3);

        // Mode 11: repeating count of 2, done pulses every second step.
        issue(WrCr, 4'b0011);
        issue(LoadWc, 4'd2);
        issue(Enable, 4'd0);
        bus.cnte = 1'b1;
        mask     = 6'b0;
        busy_cnt = 0;
        ena_cnt  = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (bus.ena) ena_cnt++;
            tick();
            if (bus.done) mask[k] = 1'b1;
            if (bus.busy) busy_cnt++;
        end
        check_eq("m3_done_mask", mask, 6'b101010);
        check_eq("m3_busy", busy_cnt, 6);
        check_eq("m3_ena", ena_cnt, 6);
        bus.instr       = LoadAddr;
        bus.instr_valid = 1'b1;
        #1;
        check_eq("m3_plar", bus.plar, 1);
        check_eq("m3_plac", bus.plac, 1);
        check_eq("m3_sela", bus.sela, 0);
        check_eq("m3_ena_instr", bus.ena, 0);
        tick();
        bus.instr_valid = 1'b0;
        check_eq("m3_idle", bus.busy, 0);
        check_eq("m3_done_idle", bus.done, 0);
        bus.cnte = 1'b0;
        read_check(RdWc, "m3_wc", 4'd2);

        // Reset mid-transfer in mode 00.
        issue(WrCr, 4'b0000);
        issue(LoadWc, 4'd5);
        issue(Enable, 4'd0);
        bus.cnte = 1'b1;
        for (int s = 0; s < 2; s++) begin
            #1;
            check_eq($sformatf("rst_run_ena%0d", s), bus.ena, 1);
            tick();
        end
        res = 1'b0;
        tick();
        res = 1'b1;
        #1;
        check_eq("rst_run_busy", bus.busy, 0);
        check_eq("rst_run_ena", bus.ena, 0);
        check_eq("rst_run_done", bus.done, 0);
        bus.cnte = 1'b0;
        read_check(RdWc, "rst_run_wc", 4'd0);

`ifdef AM2940_AUTO_REINIT_EN
        issue(WrCr, 4'b0000);
        issue(LoadWc, 4'd2);
        issue(Enable, 4'd0);
        bus.cnte = 1'b1;
        run_until_done(10, pulses);
        check_eq("ar_pulses", pulses, 2);
        check_eq("ar_done", bus.done, 1);
        check_eq("ar_plac", bus.plac, 1);
        check_eq("ar_sela", bus.sela, 1);
        tick();
        check_eq("ar_done_drop", bus.done, 0);
        check_eq("ar_idle", bus.busy, 0);
        check_eq("ar_plac_drop", bus.plac, 0);
        bus.cnte = 1'b0;
        read_check(RdWc, "ar_wc", 4'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
